// File: rtl/lbdr_pkg.sv
// Shared definitions for the LBDR routing unit with deroute fallback.
// Holds the flit type codes, the port index constants, the deroute port
// code type, the hold FSM state type and the flit-code decode helpers.
package lbdr_pkg;

    // Flit type codes. Bit 0 marks a header and bit 2 marks a tail, so a
    // single-flit packet carries both bits.
    localparam logic [2:0] HEADER   = 3'b001;
    localparam logic [2:0] BODY     = 3'b010;
    localparam logic [2:0] TAIL     = 3'b100;
    localparam logic [2:0] HEADTAIL = 3'b101;

    // Bit positions in the one-hot route vector {L,S,W,E,N}.
    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_W = 2;
    localparam int P_S = 3;
    localparam int P_L = 4;
    localparam int NUM_PORTS = 5;

    // Deroute port code: 0=N 1=E 2=W 3=S. These match the P_* indices and
    // the Cx bit order, so the code directly indexes both.
    typedef logic [1:0] port_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic is_head(input logic [2:0] id);
        return (id == HEADER) || (id == HEADTAIL);
    endfunction

    function automatic logic is_tail(input logic [2:0] id);
        return (id == TAIL) || (id == HEADTAIL);
    endfunction

endpackage

// File: rtl/lbdr_route_calc.sv
// Combinational LBDR route computation with deroute fallback.
// Ports:
//   cur, dst    : own / destination address, Y in upper half, X in lower
//   rxy         : routing bits [0]Rne [1]Rnw [2]Ren [3]Res
//                              [4]Rwn [5]Rws [6]Rse [7]Rsw
//   cx          : connectivity [0]Cn [1]Ce [2]Cw [3]Cs
//   dr          : deroute port code
//   port        : one-hot {L,S,W,E,N}; may carry two minimal ports
//   derouted    : no minimal port was usable, the deroute port was taken
//   unroutable  : no minimal port and the deroute port is disconnected
module lbdr_route_calc
    import lbdr_pkg::*;
#(
    parameter int COORD_W = 2
) (
    input  logic [2*COORD_W-1:0]  cur,
    input  logic [2*COORD_W-1:0]  dst,
    input  logic [7:0]            rxy,
    input  logic [3:0]            cx,
    input  port_code_t            dr,
    output logic [NUM_PORTS-1:0]  port,
    output logic                  derouted,
    output logic                  unroutable
);

    logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
    logic n1, s1, e1, w1;
    logic r_ne, r_nw, r_en, r_es, r_wn, r_ws, r_se, r_sw;
    logic p_n, p_e, p_w, p_s, p_l;
    logic [3:0] min_vec;
    logic [3:0] dr_vec;

    assign x_cur = cur[COORD_W-1:0];
    assign y_cur = cur[2*COORD_W-1:COORD_W];
    assign x_dst = dst[COORD_W-1:0];
    assign y_dst = dst[2*COORD_W-1:COORD_W];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;

    assign {r_sw, r_se, r_ws, r_wn, r_es, r_en, r_nw, r_ne} = rxy;

    assign p_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & r_ne) | (n1 & w1 & r_nw)) & cx[P_N];
    assign p_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & r_en) | (e1 & s1 & r_es)) & cx[P_E];
    assign p_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & r_wn) | (w1 & s1 & r_ws)) & cx[P_W];
    assign p_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & r_se) | (s1 & w1 & r_sw)) & cx[P_S];
    assign p_l = ~n1 & ~e1 & ~w1 & ~s1;

    assign min_vec = {p_s, p_w, p_e, p_n};
    assign dr_vec  = 4'b0001 << dr;

    always_comb begin
        port       = '0;
        derouted   = 1'b0;
        unroutable = 1'b0;
        if (p_l) begin
            port[P_L] = 1'b1;
        end else if (|min_vec) begin
            port[3:0] = min_vec;
        end else if (cx[dr]) begin
            port[3:0] = dr_vec;
            derouted  = 1'b1;
        end else begin
            unroutable = 1'b1;
        end
    end

endmodule

// File: rtl/lbdr_dr.sv
// LBDR routing unit with deroute fallback and per-packet hold FSM.
// Sits between an input buffer and the switch allocator: computes the
// output port of each packet from its header and holds it until the tail
// flit is popped.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   cfg_we, cfg_rxy, cfg_cx,
//   cfg_addr, cfg_dr          : run-time configuration write
//   flit_valid, flit_id,
//   dst_addr, flit_pop        : buffer head flit and allocator consume
//   route_valid, route_port,
//   route_derouted, route_err : registered routing result and error pulse
module lbdr_dr
    import lbdr_pkg::*;
#(
    parameter int          COORD_W   = 2,
    parameter logic [7:0]  RXY_INIT  = 8'h3C,
    parameter logic [3:0]  CX_INIT   = 4'hF,
    parameter int          ADDR_INIT = 5,
    parameter logic [1:0]  DR_INIT   = 2'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [7:0]            cfg_rxy,
    input  logic [3:0]            cfg_cx,
    input  logic [2*COORD_W-1:0]  cfg_addr,
    input  logic [1:0]            cfg_dr,
    input  logic                  flit_valid,
    input  logic [2:0]            flit_id,
    input  logic [2*COORD_W-1:0]  dst_addr,
    input  logic                  flit_pop,
    output logic                  route_valid,
    output logic [NUM_PORTS-1:0]  route_port,
    output logic                  route_derouted,
    output logic                  route_err
);

    localparam int ADDR_W = 2 * COORD_W;

    logic [7:0]        rxy_q;
    logic [3:0]        cx_q;
    logic [ADDR_W-1:0] addr_q;
    port_code_t        dr_q;

    state_t state_q, state_n;
    logic [NUM_PORTS-1:0] port_n;
    logic der_n, valid_n, err_n;
    // Set while the header that produced the held route is still at the
    // buffer head; distinguishes it from a new header arriving mid-packet.
    logic head_taken_q, head_taken_n;

    logic [NUM_PORTS-1:0] calc_port;
    logic calc_der, calc_unr;

    lbdr_route_calc #(.COORD_W(COORD_W)) u_calc (
        .cur        (addr_q),
        .dst        (dst_addr),
        .rxy        (rxy_q),
        .cx         (cx_q),
        .dr         (dr_q),
        .port       (calc_port),
        .derouted   (calc_der),
        .unroutable (calc_unr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxy_q  <= RXY_INIT;
            cx_q   <= CX_INIT;
            addr_q <= ADDR_W'(ADDR_INIT);
            dr_q   <= DR_INIT;
        end else if (cfg_we) begin
            rxy_q  <= cfg_rxy;
            cx_q   <= cfg_cx;
            addr_q <= cfg_addr;
            dr_q   <= cfg_dr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            head_taken_q   <= 1'b0;
            route_valid    <= 1'b0;
            route_port     <= '0;
            route_derouted <= 1'b0;
            route_err      <= 1'b0;
        end else begin
            state_q        <= state_n;
            head_taken_q   <= head_taken_n;
            route_valid    <= valid_n;
            route_port     <= port_n;
            route_derouted <= der_n;
            route_err      <= err_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        head_taken_n = head_taken_q;
        valid_n      = route_valid;
        port_n       = route_port;
        der_n        = route_derouted;
        err_n        = 1'b0;
        if (flit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (is_head(flit_id)) begin
                        state_n      = BUSY;
                        head_taken_n = 1'b1;
                        valid_n      = 1'b1;
                        port_n       = calc_port;
                        der_n        = calc_der;
                        err_n        = calc_unr;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                BUSY: begin
                    if (is_head(flit_id) && !head_taken_q) begin
                        // Previous packet lost its tail: flag it and
                        // re-route from the new header.
                        head_taken_n = 1'b1;
                        port_n       = calc_port;
                        der_n        = calc_der;
                        err_n        = 1'b1;
                    end else if (flit_pop) begin
                        head_taken_n = 1'b0;
                        if (is_tail(flit_id)) begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                            port_n  = '0;
                            der_n   = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: doc/lbdr_dr.md
Name: lbdr_dr

Overview:
- Parametrised successor to the minimal-routing LBDR unit.
- Computes the output port for each packet at an input port of a 2D-mesh router.
- Supports arbitrary mesh coordinate width, a deroute fallback port and a per-packet hold state machine.
- Configuration (routing bits, connectivity bits, own address, deroute port) is software-writable at run time. The block sits between the input buffer and the switch allocator.

Parameters:
- COORD_W, 2, bits per X/Y coordinate; address width ADDR_W = 2*COORD_W (Y in upper half, X in lower half).
- RXY_INIT, 8'h3C, routing bits after reset: [0]Rne [1]Rnw [2]Ren [3]Res [4]Rwn [5]Rws [6]Rse [7]Rsw.
- CX_INIT, 4'hF, connectivity after reset: [0]Cn [1]Ce [2]Cw [3]Cs.
- ADDR_INIT, 5, own address after reset.
- DR_INIT, 2'd0, deroute port code after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  configuration write strobe
- cfg_rxy  in  8  routing bits
- cfg_cx  in  4  connectivity bits
- cfg_addr  in  ADDR_W  own router address
- cfg_dr  in  2  deroute port: 0=N 1=E 2=W 3=S
- flit_valid  in  1  flit present at buffer head
- flit_id  in  3  HEADER/BODY/TAIL code
- dst_addr  in  ADDR_W  destination; sampled on HEADER only
- flit_pop  in  1  allocator consumed current flit
- route_valid  out  1  port vector valid for current packet
- route_port  out  5  one-hot {L,S,W,E,N}; bit0=N
- route_derouted  out  1  current packet took the deroute port
- route_err  out  1  one-cycle protocol/unroutable error pulse

Behaviour:
- Reset (rst=0, async):
  - Config registers take their *_INIT values.
  - FSM goes to IDLE.
  - route_valid=0, route_port=0, route_derouted=0, route_err=0.
- cfg_we=1 loads all four config registers on the next edge, in any state. New values affect only subsequently accepted headers; route_port of a packet in flight is never changed.
- Comparators: N1=y_dst<y_cur, S1=y_cur<y_dst, E1=x_cur<x_dst, W1=x_dst<x_cur. Unsigned compare, COORD_W wide.
- Minimal port terms:
  - N=((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw))&Cn
  - E=((E1&~N1&~S1)|(E1&N1&Ren)|(E1&S1&Res))&Ce
  - W=((W1&~N1&~S1)|(W1&N1&Rwn)|(W1&S1&Rws))&Cw
  - S=((S1&~E1&~W1)|(S1&E1&Rse)|(S1&W1&Rsw))&Cs
  - L=~N1&~E1&~W1&~S1
- Deroute: if L=0 and {N,E,W,S}=0, select the port given by dr, provided its C bit is 1. Then route_derouted=1.
- Unroutable: the deroute port is also disconnected. route_err pulses, the packet is routed nowhere (route_port=0, route_valid=1) and is drained until TAIL.
- Multi-bit results (two minimal ports) are allowed only via Rxy; route_port may then carry 2 bits set. The allocator chooses.
- FSM IDLE:
  - flit_valid & flit_id==HEADER: compute, register route_port and route_derouted at the next edge (latency 1), set route_valid=1, go BUSY.
  - BODY/TAIL in IDLE: route_err pulse, no state change.
- FSM BUSY:
  - route_port is held.
  - flit_pop on a TAIL flit: next edge route_valid=0, route_port=0, go IDLE.
  - HEADER seen while BUSY (missing tail): route_err pulse, recompute from the new header, stay BUSY.
- Single-flit packet (HEADER code with the tail bit; see package) routes and returns to IDLE after its pop.
- flit_valid=0 never changes state. route_err is always exactly one cycle.

Decomposition:
- Shared package lbdr_pkg:
  - flit codes HEADER=3'b001, BODY=3'b010, TAIL=3'b100, HEADTAIL=3'b101.
  - port index constants P_N..P_L.
  - port-code typedef port_code_t (2 bits).
  - FSM state enum {IDLE,BUSY}.
- One natural sub-module, lbdr_route_calc: purely combinational comparator, minimal-term and deroute logic. Inputs: cur/dst/Rxy/Cx/dr. Outputs: port vector, derouted, unroutable.
- lbdr_dr holds the config registers, FSM and output registers.

Test Plan:
- Reset defaults (cur=5: x1,y1), HEADER dst=0 -> next cycle route_port=5'b00100 (W), route_valid=1, derouted=0.
- HEADER dst=7, BODY, TAIL with pops -> route_port=00010 (E) held for all three flits; cleared and route_valid=0 the cycle after the TAIL pop.
- HEADER dst=5 -> route_port=10000 (L).
- cfg_cx=4'b1011 (Cw=0), cfg_dr=0, HEADER dst=0 -> route_port=00001 (N), derouted=1. Then cfg_cx=4'b1010, repeat -> route_err pulse, route_port=0, then drain to TAIL.
- BODY while IDLE -> route_err for one cycle, state stays IDLE. HEADER while BUSY -> route_err pulse, route_port recomputed from the new dst.
- Assert rst low mid-packet (BUSY, route_port=E) -> all outputs 0 immediately (asynchronously), config back to INIT values, next HEADER routed with defaults.
